// File: rtl/imem_fetch_port_if.sv
// Fetch/load bundle between the PC logic (master) and the instruction memory (slave).
// Pure wiring, no latency of its own.
// Back-pressure: req_ready and resp_ready carry flow control in each direction.
interface imem_fetch_port_if #(
    parameter int DEPTH = 32,
    parameter int AW    = 32
);
    localparam int IW = $clog2(DEPTH);

    // program-image load port
    logic          load_en;
    logic [IW-1:0] load_idx;
    logic [31:0]   load_data;

    // fetch request
    logic          req_valid;
    logic [AW-1:0] req_addr;
    logic          req_ready;

    // fetch response
    logic          resp_valid;
    logic [31:0]   resp_ins;
    logic          resp_fault;
    logic          resp_ready;

    modport master (
        output load_en, load_idx, load_data,
        output req_valid, req_addr, resp_ready,
        input  req_ready, resp_valid, resp_ins, resp_fault
    );

    modport slave (
        input  load_en, load_idx, load_data,
        input  req_valid, req_addr, resp_ready,
        output req_ready, resp_valid, resp_ins, resp_fault
    );
endinterface

// File: rtl/imem_fetch_port.sv
// Loadable DEPTH x 32 instruction memory with a valid/ready fetch port; IMEM_FAULT_CHECK_EN enables address fault reporting.
// Latency: request accepted at edge N is presented on resp_* during cycle N+1; one fetch per cycle.
// Back-pressure: a stalled response (resp_valid && !resp_ready) holds stable and drops req_ready.
module imem_fetch_port #(
    parameter int DEPTH = 32,
    parameter int AW    = 32
) (
    input  logic clk,
    input  logic rst,
    imem_fetch_port_if.slave bus
);
    localparam int IW = $clog2(DEPTH);

    // Program store; deliberately not reset so an image survives a core reset.
    logic [31:0]   mem [DEPTH];

    logic [AW-1:0] word_addr;
    logic [IW-1:0] fetch_idx;
    logic          load_ok;
    logic          fetch_fault;
    logic          collide;
    logic [31:0]   rd_word;
    logic [31:0]   next_ins;
    logic          accept;

    logic          resp_valid_q;
    logic [31:0]   resp_ins_q;
    logic          resp_fault_q;

    assign word_addr = bus.req_addr >> 2;
    assign fetch_idx = word_addr[IW-1:0];

`ifdef IMEM_FAULT_CHECK_EN
    // Only matters if the load index is ever widened beyond the array.
    assign load_ok     = ({1'b0, bus.load_idx} < (IW+1)'(DEPTH));
    assign fetch_fault = (bus.req_addr[1:0] != 2'b00) || (word_addr >= AW'(DEPTH));
`else
    // Without checking, the byte offset is ignored and the index wraps modulo DEPTH.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{word_addr[AW-1:IW], bus.req_addr[1:0]};
    assign load_ok     = 1'b1;
    assign fetch_fault = 1'b0;
`endif

    // A load to the word being fetched on the same edge is forwarded (write-first).
    assign collide  = bus.load_en && load_ok && (bus.load_idx == fetch_idx);
    assign rd_word  = collide ? bus.load_data : mem[fetch_idx];
    assign next_ins = fetch_fault ? 32'h0000_0000 : rd_word;

    // The response stage can take a new word when empty or when it retires this cycle.
    assign bus.req_ready = !resp_valid_q || bus.resp_ready;
    assign accept        = bus.req_valid && bus.req_ready;

    // Image write port, independent of reset and of the fetch handshake.
    always_ff @(posedge clk) begin
        if (bus.load_en && load_ok) begin
            mem[bus.load_idx] <= bus.load_data;
        end
    end

    // Response register: load on accept, clear on retire, hold while stalled.
    always_ff @(posedge clk) begin
        if (!rst) begin
            resp_valid_q <= 1'b0;
            resp_ins_q   <= 32'h0000_0000;
            resp_fault_q <= 1'b0;
        end else if (accept) begin
            resp_valid_q <= 1'b1;
            resp_ins_q   <= next_ins;
            resp_fault_q <= fetch_fault;
        end else if (bus.resp_ready) begin
            resp_valid_q <= 1'b0;
        end
    end

    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_ins   = resp_ins_q;
    assign bus.resp_fault = resp_fault_q;
endmodule

// File: tb/tb_imem_fetch_port.sv
// Self-checking bench for imem_fetch_port: per-cycle vector table plus a response scoreboard.
// Expected response words are pushed when a request is expected to be accepted and popped on retirement.
// Ends with one TB_RESULT summary line.
module tb_imem_fetch_port;
    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    imem_fetch_port_if #(.DEPTH(32), .AW(32)) bus ();

    imem_fetch_port #(.DEPTH(32), .AW(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic        rst;
        logic        ld_en;
        logic [4:0]  ld_idx;
        logic [31:0] ld_data;
        logic        req_v;
        logic [31:0] addr;
        logic        rrdy;
        logic        e_rdy;   // req_ready expected this cycle
        logic        e_vld;   // resp_valid expected this cycle
        logic [31:0] e_ins;   // response expected for this request
        logic        e_flt;
    } vec_t;

    typedef struct {
        logic [31:0] ins;
        logic        flt;
    } rsp_t;

    vec_t vecs[$];
    rsp_t sb[$];

    function automatic vec_t mk(logic r, logic le, logic [4:0] li, logic [31:0] ld,
                                logic rv, logic [31:0] a, logic rr,
                                logic er, logic ev, logic [31:0] ei, logic ef);
        vec_t v;
        v.rst = r;  v.ld_en = le; v.ld_idx = li; v.ld_data = ld;
        v.req_v = rv; v.addr = a; v.rrdy = rr;
        v.e_rdy = er; v.e_vld = ev; v.e_ins = ei; v.e_flt = ef;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        rst            = v.rst;
        bus.load_en    = v.ld_en;
        bus.load_idx   = v.ld_idx;
        bus.load_data  = v.ld_data;
        bus.req_valid  = v.req_v;
        bus.req_addr   = v.addr;
        bus.resp_ready = v.rrdy;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] f6_ins, f80_ins;
        logic        f6_flt, f80_flt;
        int          n;
        rsp_t        r;

`ifdef IMEM_FAULT_CHECK_EN
        f6_ins = 32'h0000_0000; f6_flt = 1'b1;
        f80_ins = 32'h0000_0000; f80_flt = 1'b1;
`else
        f6_ins = 32'h2040_0004; f6_flt = 1'b0;
        f80_ins = 32'h0084_5002; f80_flt = 1'b0;
`endif

        //            rst le idx   ld_data       rv addr        rr  erdy evld e_ins          e_flt
        vecs.push_back(mk(1, 1, 5'd0,  32'h0084_5002, 0, 32'h0,    1,  1, 0, 32'h0,         0));
        vecs.push_back(mk(1, 1, 5'd1,  32'h2040_0004, 0, 32'h0,    1,  1, 0, 32'h0,         0));
        vecs.push_back(mk(1, 1, 5'd31, 32'hCAFE_F00D, 0, 32'h0,    1,  1, 0, 32'h0,         0));
        vecs.push_back(mk(1, 0, 5'd0,  32'h0,         1, 32'h0,    1,  1, 0, 32'h0084_5002, 0));
        vecs.push_back(mk(1, 0, 5'd0,  32'h0,         1, 32'h4,    1,  1, 1, 32'h2040_0004, 0));
        vecs.push_back(mk(1, 0, 5'd0,  32'h0,         1, 32'h8,    0,  0, 1, 32'h0,         0));
        vecs.push_back(mk(1, 0, 5'd0,  32'h0,         1, 32'h8,    0,  0, 1, 32'h0,         0));
        vecs.push_back(mk(1, 0, 5'd0,  32'h0,         1, 32'h8,    0,  0, 1, 32'h0,         0));
        vecs.push_back(mk(1, 1, 5'd2,  32'hDEAD_BEEF, 1, 32'h8,    1,  1, 1, 32'hDEAD_BEEF, 0));
        vecs.push_back(mk(1, 0, 5'd0,  32'h0,         1, 32'h7C,   1,  1, 1, 32'hCAFE_F00D, 0));
        vecs.push_back(mk(1, 0, 5'd0,  32'h0,         1, 32'h6,    1,  1, 1, f6_ins,        f6_flt));
        vecs.push_back(mk(1, 0, 5'd0,  32'h0,         1, 32'h80,   1,  1, 1, f80_ins,       f80_flt));
        vecs.push_back(mk(1, 0, 5'd0,  32'h0,         0, 32'h0,    0,  0, 1, 32'h0,         0));
        vecs.push_back(mk(0, 0, 5'd0,  32'h0,         1, 32'h4,    1,  1, 1, 32'h0,         0));
        vecs.push_back(mk(1, 0, 5'd0,  32'h0,         0, 32'h0,    1,  1, 0, 32'h0,         0));
        vecs.push_back(mk(1, 0, 5'd0,  32'h0,         1, 32'h0,    1,  1, 0, 32'h0084_5002, 0));
        vecs.push_back(mk(1, 1, 5'd1,  32'h1234_5678, 1, 32'h4,    1,  1, 1, 32'h1234_5678, 0));
        vecs.push_back(mk(1, 0, 5'd0,  32'h0,         0, 32'h0,    1,  1, 1, 32'h0,         0));
        vecs.push_back(mk(1, 0, 5'd0,  32'h0,         0, 32'h0,    1,  1, 0, 32'h0,         0));

        // Power-on reset for two cycles with idle inputs.
        drive(mk(0, 0, 5'd0, 32'h0, 0, 32'h0, 1, 0, 0, 32'h0, 0));
        repeat (2) @(posedge clk);
        #1;

        foreach (vecs[i]) begin
            drive(vecs[i]);
            @(negedge clk);
            chk($sformatf("row%0d req_ready", i), 32'(bus.req_ready), 32'(vecs[i].e_rdy));
            chk($sformatf("row%0d resp_valid", i), 32'(bus.resp_valid), 32'(vecs[i].e_vld));
            if (vecs[i].e_vld) begin
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL row%0d scoreboard: response present, got %h expected none", i, bus.resp_ins);
                end else begin
                    r = sb[0];
                    chk($sformatf("row%0d resp_ins", i), bus.resp_ins, r.ins);
                    chk($sformatf("row%0d resp_fault", i), 32'(bus.resp_fault), 32'(r.flt));
                    if (vecs[i].rrdy) void'(sb.pop_front());
                end
            end
            if (!vecs[i].rst) begin
                sb.delete();
            end else if (vecs[i].req_v && vecs[i].e_rdy) begin
                r.ins = vecs[i].e_ins;
                r.flt = vecs[i].e_flt;
                sb.push_back(r);
            end
            @(posedge clk);
            #1;
        end

        // Stalled response with collision load: response must appear and then hold.
        drive(mk(1, 1, 5'd5, 32'h0BAD_F00D, 1, 32'h14, 0, 0, 0, 32'h0, 0));
        @(negedge clk);
        chk("stall accept req_ready", 32'(bus.req_ready), 32'd1);
        @(posedge clk);
        #1;
        bus.load_en   = 1'b0;
        bus.req_valid = 1'b1;
        bus.req_addr  = 32'h0;
        n = 0;
        while (!bus.resp_valid && n < 8) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 8) begin
            checks++;
            failures++;
            $display("FAIL stall wait: resp_valid got 0 expected 1 within 8 cycles");
        end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk($sformatf("stall%0d resp_ins", k), bus.resp_ins, 32'h0BAD_F00D);
            chk($sformatf("stall%0d req_ready", k), 32'(bus.req_ready), 32'd0);
        end
        @(posedge clk);
        #1;
        bus.req_valid  = 1'b0;
        bus.resp_ready = 1'b1;
        @(negedge clk);
        chk("release req_ready", 32'(bus.req_ready), 32'd1);
        chk("release resp_valid", 32'(bus.resp_valid), 32'd1);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("drained resp_valid", 32'(bus.resp_valid), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/imem_fetch_port.md
# imem_fetch_port

Parametrised, loadable instruction memory with a valid/ready fetch interface. It replaces the hard-coded, reset-loaded program store that sits between the PC logic and the decoder. The program image is written through a dedicated load port. Fetches return one registered response per accepted request, with back-pressure and optional address fault detection.

## Interface
- DEPTH, 32: number of 32-bit instruction words; power of 2, ≥ 2.
- AW, 32: byte-address width of fetch requests.
- IW, $clog2(DEPTH): word-index width of the load port (derived, not overridden).
- clk  in  1  single clock; all logic on posedge.
- rst  in  1  reset; synchronous, active-low (asserted when 0, sampled on posedge clk).
- load_en  in  1  write one instruction word this cycle.
- load_idx  in  IW  word index to write.
- load_data  in  32  instruction word to write.
- req_valid  in  1  fetch request present.
- req_addr  in  AW  byte address of the instruction.
- req_ready  out  1  request accepted when req_valid && req_ready.
- resp_valid  out  1  response present.
- resp_ins  out  32  fetched instruction.
- resp_fault  out  1  request address was invalid; resp_ins forced to 32'h0000_0000 (NOP).
- resp_ready  in  1  consumer accepts response when resp_valid && resp_ready.

## Operation
- Storage: DEPTH × 32 array. It is not cleared by reset; contents persist across reset and are undefined until loaded.
- Load: if load_en=1 on a posedge, mem[load_idx] <= load_data. Loads are independent of rst and of the fetch handshake.
- Fetch accept: req_ready = !resp_valid || resp_ready (combinational). An accepted request is registered into the response stage on the same edge.
- Word index = req_addr >> 2, low IW bits.
- Fault, when IMEM_FAULT_CHECK_EN is defined:
  - req_addr[1:0] != 0 (misaligned), or
  - req_addr >> 2 ≥ DEPTH (out of range).
  - On a fault: resp_fault=1 and resp_ins=0.
- Response register:
  - On accept: resp_valid <= 1, with resp_ins and resp_fault loaded.
  - Else, if resp_ready: resp_valid <= 0.
  - Else: hold resp_valid, resp_ins and resp_fault unchanged.
- Load/fetch collision (same edge, same word): write-first. The response carries load_data.
- Reset (rst=0 at posedge): resp_valid=0, resp_ins=0, resp_fault=0. Reset overrides any accept in that cycle; an in-flight response is dropped. req_ready=1 from the first cycle after reset.

## Timing
- Latency: a request accepted at edge N is visible on resp_* after edge N, i.e. during cycle N+1.
- Throughput: one fetch per cycle while resp_ready=1.
- Back-pressure:
  - resp_valid=1 and resp_ready=0 → req_ready=0, and the response is held stable.
  - Resp is held stable until the cycle in which resp_ready=1.
- Handshake transfers:
  - req_valid=1 and req_ready=0 → no transfer; the requester must hold req_addr.
  - resp_valid && resp_ready and req_valid in the same cycle → the old response retires and the new one loads on that edge (no bubble).
- Load visibility: a word written at edge N is visible to a fetch accepted at edge N (write-first) or any later edge.
- Outputs are registered except req_ready. req_ready depends combinationally on resp_ready; there is no path from req_* to req_ready.

## Configuration
- IMEM_FAULT_CHECK_EN defined:
  - Misaligned and out-of-range fetches return resp_fault=1 and resp_ins=0.
  - Loads with load_idx ≥ DEPTH are ignored (relevant only if IW is overridden).
- IMEM_FAULT_CHECK_EN undefined:
  - resp_fault is tied to 0.
  - req_addr[1:0] is ignored.
  - The word index wraps modulo DEPTH, i.e. mem[(req_addr>>2) & (DEPTH-1)].

## Test plan
- Reset then load: rst=0 for 2 cycles, then rst=1; load mem[0]=32'h0084_5002, mem[1]=32'h2040_0004; fetch 0x0 then 0x4 back-to-back with resp_ready=1 → resp_ins 0x00845002 then 0x20400004 on consecutive cycles, resp_fault=0, resp_valid=0 in the first post-reset cycle.
- Back-pressure: fetch 0x4 with resp_ready=0 for 3 cycles while req_valid=1 with addr 0x8 → req_ready=0 and resp_ins stays 0x20400004; at resp_ready=1, 0x8's word follows the next cycle.
- Collision: in the same cycle, load mem[2]=32'hDEAD_BEEF and accept a fetch of 0x8 → resp_ins=0xDEADBEEF.
- Faults (IMEM_FAULT_CHECK_EN defined, DEPTH=32):
  - Fetch 0x6 → resp_fault=1, resp_ins=0.
  - Fetch 0x80 → resp_fault=1, resp_ins=0.
  - Fetch 0x7C → resp_fault=0, returns mem[31].
- Faults disabled: fetch 0x80 → resp_ins=mem[0], resp_fault=0; fetch 0x6 → mem[1].
- Mid-operation reset: response pending with resp_ready=0, then rst=0 for 1 cycle → resp_valid=0 next cycle; memory contents unchanged, so a refetch of 0x0 still returns 0x00845002.
